alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter EXEC_CYCLES, default 2, legal 1..15: cycles the external ALU needs to settle.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 clear_n  input  1: synchronous, active-low reset.
REQ-005 start  input  1: request one operation; accepted only in IDLE.
REQ-006 op  input  3: ALU opcode, latched when start is accepted.
REQ-007 abort  input  1: cancel current operation.
REQ-008 din  input  WIDTH: shared operand bus, carries A then B.
REQ-009 din_valid  input  1: din holds a valid operand this cycle.
REQ-010 din_ready  output  1: controller will capture din this cycle if din_valid=1.
REQ-011 alu_res  input  WIDTH: external ALU result.
REQ-012 alu_zero, alu_ovf  input  1 each: external ALU flags.
REQ-013 a_q, b_q  output  WIDTH: latched operands driving the ALU.
REQ-014 op_q  output  3: latched opcode driving the ALU.
REQ-015 result  output  WIDTH: latched ALU result.
REQ-016 flags  output  2: {ovf, zero} of last completed operation.
REQ-017 busy  output  1: high in every state except IDLE.
REQ-018 done  output  1: one-cycle pulse on completion.

Function
REQ-019 FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE.
REQ-020 IDLE -> LOAD_A when start=1 and abort=0; op latched into op_q on that edge.
REQ-021 LOAD_A: din_ready=1; when din_valid=1, a_q<=din, go LOAD_B; otherwise hold indefinitely.
REQ-022 LOAD_B: din_ready=1; when din_valid=1, b_q<=din, go EXEC; otherwise hold.
REQ-023 EXEC: 4-bit counter loaded with EXEC_CYCLES-1 on entry; decrements each cycle; go WRITE after it reaches 0 (exactly EXEC_CYCLES cycles in EXEC).
REQ-024 WRITE: result<=alu_res, flags updated per REQ-033, go DONE; lasts exactly 1 cycle.
REQ-025 DONE: done=1 for exactly 1 cycle, then IDLE; result, a_q, b_q, op_q hold until overwritten.
REQ-026 Latency with din_valid held high: start sampled at edge 0 -> done high during cycle EXEC_CYCLES+4.
REQ-027 start while busy=1 is ignored, not queued.
REQ-028 abort=1 in any non-IDLE state -> IDLE next edge; no done; result/flags unchanged; a_q/b_q keep any partially loaded value.
REQ-029 abort and start both high in IDLE -> stay IDLE.
REQ-030 din_ready=0 outside LOAD_A/LOAD_B; din ignored there.
REQ-031 Back-to-back: start accepted in the cycle immediately after DONE returns to IDLE.

Reset
REQ-032 clear_n=0 at a rising edge -> state IDLE, counter 0, a_q, b_q, result all 0, op_q 0, flags 0, busy 0, done 0, din_ready 0; takes priority over start and abort, including mid-operation.

Configuration
REQ-033 With macro ALU_SEQ_FLAGS_EN defined, WRITE captures flags<={alu_ovf, alu_zero}; without it, flags is constant 0 and alu_ovf/alu_zero are unused; port list is identical in both builds.

Structure
REQ-034 Shared package alu_seq_pkg holds the state enum, opcode width constant (3) and the EXEC counter width constant (4).
REQ-035 One sub-module seq_reg: WIDTH-bit register with synchronous active-low clear and load enable, instantiated for a_q, b_q and result.

Verification
REQ-036 Reset: start=1, din_valid=1 with clear_n=0 for 3 cycles -> all outputs 0, busy=0.
REQ-037 Nominal: start, op=3'b010, din=32'hAAAAAAAA then 32'h55555555, alu_res model = 32'hFFFFFFFF, EXEC_CYCLES=2 -> a_q=AAAAAAAA, b_q=55555555, result=FFFFFFFF, done pulse in cycle 6, busy high cycles 1..6.
REQ-038 Stall: din_valid low 5 cycles in LOAD_A -> din_ready stays 1, a_q unchanged, done delayed by exactly 5 cycles.
REQ-039 Abort in EXEC after prior result 32'h5A5A5A5A -> IDLE next cycle, no done, result still 5A5A5A5A.
REQ-040 Start while busy and start+abort in IDLE -> both ignored; a later start at cycle after DONE completes normally.
REQ-041 Flags: alu_res=0, alu_zero=1, alu_ovf=1 -> flags=2'b11 with ALU_SEQ_FLAGS_EN, 2'b00 without.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and widths for the ALU sequencer
package alu_seq_pkg;
  localparam int OP_W = 3;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE} state_t;
endpackage

// File: rtl/alu_seq_ctrl_seq_reg.sv
// seq_reg: WIDTH-bit register with sync active-low clear (clear_n) and load enable (en); d in, q out
module seq_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (!clear_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: loads A/B from a shared bus, waits EXEC_CYCLES for an external ALU, latches result; ALU_SEQ_FLAGS_EN enables {ovf,zero} capture
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [OP_W-1:0]  op_q,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags,
  output logic             busy,
  output logic             done
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_d;
  logic busy_q, done_q, din_ready_q;
  logic ld_a, ld_b, ld_r;
  always_comb begin
    ld_a = state_q == LOAD_A && din_valid && !abort;
    ld_b = state_q == LOAD_B && din_valid && !abort;
    ld_r = state_q == WRITE && !abort;
    op_d = (state_q == IDLE && start && !abort) ? op : op_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE:    state_d = (start && !abort) ? LOAD_A : IDLE;
      LOAD_A:  state_d = din_valid ? LOAD_B : LOAD_A;
      LOAD_B: begin
        state_d = din_valid ? EXEC : LOAD_B;
        cnt_d = din_valid ? CNT_INIT : cnt_q;
      end
      EXEC: begin
        state_d = cnt_q == '0 ? WRITE : EXEC;
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      din_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
      din_ready_q <= state_d == LOAD_A || state_d == LOAD_B;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign din_ready = din_ready_q;
  seq_reg #(.WIDTH(WIDTH)) u_a (.clk(clk), .clear_n(clear_n), .en(ld_a), .d(din), .q(a_q));
  seq_reg #(.WIDTH(WIDTH)) u_b (.clk(clk), .clear_n(clear_n), .en(ld_b), .d(din), .q(b_q));
  seq_reg #(.WIDTH(WIDTH)) u_r (.clk(clk), .clear_n(clear_n), .en(ld_r), .d(alu_res), .q(result));
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0] flags_q;
  always_ff @(posedge clk)
    if (!clear_n) flags_q <= '0;
    else if (ld_r) flags_q <= {alu_ovf, alu_zero};
  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = alu_ovf ^ alu_zero;
  assign flags = '0;
`endif
endmodule
